vend_credit_ctrl: RTL

- Credit and purchase sequencer for the coke vending machine.
- Owns the 5-bit credit register and time-shares the single 5-bit CLA adder/subtractor across three jobs: coin accumulation, price check/deduction, and change payout.
- Drives the adder's operands and carry-in (Cin=1 selects subtract), then samples its sum and carry-out in the same cycle.
- Sits between the coin/button front end and the dispense/change actuators.

---
 rtl/vend_credit_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/vend_credit_ctrl.sv
// Credit/purchase sequencer for the vending machine: time-shares one external 5-bit adder
// across coin accumulation, price check and greedy change payout. Optional stock: VEND_STOCK_EN.
module vend_credit_ctrl #(
    parameter int unsigned PRICE      = 15,
    parameter int unsigned STOCK_INIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_1,
    input  logic       coin_5,
    input  logic       coin_10,
    input  logic       buy,
    input  logic       cancel,
    input  logic       restock,
    output logic [4:0] add_a,
    output logic [4:0] add_b,
    output logic       add_sub,
    input  logic [4:0] add_s,
    input  logic       add_c,
    output logic [4:0] credit,
    output logic       busy,
    output logic       coin_reject,
    output logic       deny,
    output logic       dispense,
    output logic       change_10,
    output logic       change_5,
    output logic       change_1,
    output logic       sold_out
);

    typedef enum logic [2:0] {StIdle, StAdd, StChk, StDisp, StChg} state_e;

    localparam logic [4:0] PriceVal = 5'(PRICE);

    state_e     state_q, state_d;
    logic [4:0] credit_q, credit_d;
    logic [4:0] coin_val_q, coin_val_d;
    logic [4:0] ptr_q, ptr_d;
    logic       coin_reject_q, coin_reject_d;
    logic       deny_q, deny_d;
    logic       dispense_q, dispense_d;
    logic       change_10_q, change_10_d;
    logic       change_5_q, change_5_d;
    logic       change_1_q, change_1_d;
    logic [1:0] coin_cnt;
    logic       stock_empty;

`ifdef VEND_STOCK_EN
    localparam logic [3:0] StockInit = 4'(STOCK_INIT);
    logic [3:0] stock_q, stock_d;
    assign stock_empty = (stock_q == 4'd0);
`else
    logic unused_restock;
    assign unused_restock = restock;
    assign stock_empty    = 1'b0;
`endif

    assign coin_cnt = {1'b0, coin_1} + {1'b0, coin_5} + {1'b0, coin_10};

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_val_d    = coin_val_q;
        ptr_d         = ptr_q;
        coin_reject_d = 1'b0;
        deny_d        = 1'b0;
        dispense_d    = 1'b0;
        change_10_d   = 1'b0;
        change_5_d    = 1'b0;
        change_1_d    = 1'b0;
        add_b         = 5'd0;
        add_sub       = 1'b0;
`ifdef VEND_STOCK_EN
        stock_d       = stock_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (coin_cnt > 2'd1) begin
                    coin_reject_d = 1'b1;
                end else if (coin_cnt == 2'd1) begin
                    coin_val_d = coin_10 ? 5'd10 : (coin_5 ? 5'd5 : 5'd1);
                    state_d    = StAdd;
                end else if (buy) begin
                    if (stock_empty) deny_d  = 1'b1;
                    else             state_d = StChk;
                end else if (cancel && credit_q != 5'd0) begin
                    ptr_d   = 5'd10;
                    state_d = StChg;
                end
`ifdef VEND_STOCK_EN
                if (restock) stock_d = StockInit;
`endif
            end
            StAdd: begin
                add_b = coin_val_q;
                // Carry-out on an add means the sum no longer fits in 5 bits.
                if (!add_c) credit_d      = add_s;
                else        coin_reject_d = 1'b1;
                state_d = StIdle;
            end
            StChk: begin
                add_b   = PriceVal;
                add_sub = 1'b1;
                if (add_c) begin
                    credit_d = add_s;
                    state_d  = StDisp;
                end else begin
                    deny_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StDisp: begin
                dispense_d = 1'b1;
`ifdef VEND_STOCK_EN
                stock_d    = stock_q - 4'd1;
`endif
                if (credit_q != 5'd0) begin
                    ptr_d   = 5'd10;
                    state_d = StChg;
                end else begin
                    state_d = StIdle;
                end
            end
            StChg: begin
                add_b   = ptr_q;
                add_sub = 1'b1;
                if (add_c) begin
                    credit_d = add_s;
                    if (ptr_q == 5'd10)     change_10_d = 1'b1;
                    else if (ptr_q == 5'd5) change_5_d  = 1'b1;
                    else                    change_1_d  = 1'b1;
                    if (add_s == 5'd0) state_d = StIdle;
                end else begin
                    ptr_d = (ptr_q == 5'd10) ? 5'd5 : 5'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Coins cannot be credited while the adder is owned by another job.
        if (state_q != StIdle && coin_cnt != 2'd0) coin_reject_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            credit_q      <= 5'd0;
            coin_val_q    <= 5'd0;
            ptr_q         <= 5'd10;
            coin_reject_q <= 1'b0;
            deny_q        <= 1'b0;
            dispense_q    <= 1'b0;
            change_10_q   <= 1'b0;
            change_5_q    <= 1'b0;
            change_1_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            coin_val_q    <= coin_val_d;
            ptr_q         <= ptr_d;
            coin_reject_q <= coin_reject_d;
            deny_q        <= deny_d;
            dispense_q    <= dispense_d;
            change_10_q   <= change_10_d;
            change_5_q    <= change_5_d;
            change_1_q    <= change_1_d;
        end
    end

`ifdef VEND_STOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stock_q <= StockInit;
        else     stock_q <= stock_d;
    end
`endif

    assign add_a       = credit_q;
    assign credit      = credit_q;
    assign busy        = (state_q != StIdle);
    assign coin_reject = coin_reject_q;
    assign deny        = deny_q;
    assign dispense    = dispense_q;
    assign change_10   = change_10_q;
    assign change_5    = change_5_q;
    assign change_1    = change_1_q;
    assign sold_out    = stock_empty;

endmodule
